// File: rtl/instr_encoder_loader_pkg.sv
// Shared types for the instruction encoder/loader: RV32I opcodes, command fields, loader state.
package instr_encoder_loader_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        bit30;
    logic [31:0] imm;
  } rv_cmd_t;

  typedef struct packed {
    logic        ok;
    logic [31:0] word;
  } enc_result_t;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} loader_state_e;

  // True when v is the sign extension of its low w bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic signed [31:0] hi;
    hi = $signed(v) >>> (w - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Command handshake and instruction-memory write channel of the loader.
interface instr_encoder_loader_if
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_last;
  rv_cmd_t           cmd;
  logic              imem_wr_en;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output cmd_valid, cmd_last, cmd, imem_ready,
    input  cmd_ready, imem_wr_en, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_last, cmd, imem_ready,
    output cmd_ready, imem_wr_en, imem_addr, imem_wdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead head; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs field-level RV32I commands into instruction words and streams them into
// instruction memory at consecutive addresses from a session base address.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  instr_encoder_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     words_written
);

  function automatic enc_result_t encode_cmd(input rv_cmd_t c);
    enc_result_t r;
    r.ok   = 1'b1;
    r.word = '0;
    case (c.opcode)
      OpReg: r.word = {1'b0, c.bit30, 5'b0, c.rs2, c.rs1, c.funct3, c.rd, c.opcode};
      OpImm, OpLoad: begin
        r.ok = fits_signed(c.imm, 12);
        if (c.opcode == OpImm && (c.funct3 == 3'b001 || c.funct3 == 3'b101)) begin
          r.word = {1'b0, c.bit30, 5'b0, c.imm[4:0], c.rs1, c.funct3, c.rd, c.opcode};
        end else begin
          r.word = {c.imm[11:0], c.rs1, c.funct3, c.rd, c.opcode};
        end
      end
      OpJalr: begin
        r.ok   = fits_signed(c.imm, 12);
        r.word = {c.imm[11:0], c.rs1, 3'b000, c.rd, c.opcode};
      end
      OpStore: begin
        r.ok   = fits_signed(c.imm, 12);
        r.word = {c.imm[11:5], c.rs2, c.rs1, c.funct3, c.imm[4:0], c.opcode};
      end
      OpBranch: begin
        r.ok   = fits_signed(c.imm, 13) && !c.imm[0];
        r.word = {c.imm[12], c.imm[10:5], c.rs2, c.rs1, c.funct3, c.imm[4:1], c.imm[11],
                  c.opcode};
      end
      OpLui, OpAuipc: begin
        r.ok   = (c.imm[11:0] == 12'h000);
        r.word = {c.imm[31:12], c.rd, c.opcode};
      end
      OpJal: begin
        r.ok   = fits_signed(c.imm, 21) && !c.imm[0];
        r.word = {c.imm[20], c.imm[10:1], c.imm[11], c.imm[19:12], c.rd, c.opcode};
      end
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  words_q, words_d;

  enc_result_t enc;
  logic        accept, push, pop;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;

  assign enc    = encode_cmd(bus.cmd);
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign push   = accept && enc.ok;
  assign pop    = bus.imem_wr_en && bus.imem_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (enc.word),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ready depends only on registered state, so there is no path from imem_ready.
  assign bus.cmd_ready  = (state_q == StRun) && !fifo_full;
  assign bus.imem_wr_en = !fifo_empty;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = fifo_head;

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign err           = err_q;
  assign words_written = words_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    words_d = words_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          addr_d  = base_addr;
          err_d   = 1'b0;
          words_d = '0;
        end
      end
      StRun:   if (accept && bus.cmd_last) state_d = StDrain;
      StDrain: if (fifo_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (accept && !enc.ok) err_d = 1'b1;
    if (pop) begin
      addr_d = addr_q + ADDR_W'(4);
      if (words_q != '1) words_d = words_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed commands with hand-encoded words.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        busy, done, err;
  logic [15:0] words_written;

  instr_encoder_loader_if #(.ADDR_W(32)) bus ();

  instr_encoder_loader #(
    .ADDR_W     (32),
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          fire_cnt = 0;
  int          acc_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic [31:0] model_addr;
  logic        stall_q = 1'b0;
  logic [31:0] stall_addr, stall_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every completed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (stall_q && !rst) begin
      check("hold_addr", bus.imem_addr, stall_addr);
      check("hold_data", bus.imem_wdata, stall_data);
    end
    stall_q    <= bus.imem_wr_en && !bus.imem_ready;
    stall_addr <= bus.imem_addr;
    stall_data <= bus.imem_wdata;
    if (bus.imem_wr_en && bus.imem_ready) begin
      fire_cnt <= fire_cnt + 1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, required no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", bus.imem_addr, exp_e[63:32]);
        check("wr_data", bus.imem_wdata, exp_e[31:0]);
      end
    end
  end

  task automatic do_start(input logic [31:0] b);
    start      = 1'b1;
    base_addr  = b;
    model_addr = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_cmd(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic b30,
                          input logic [31:0] imm, input logic last, input logic exp_ok,
                          input logic [31:0] exp_word);
    int n;
    n = 0;
    bus.cmd_valid      = 1'b1;
    bus.cmd_last       = last;
    bus.cmd.opcode     = op;
    bus.cmd.rd         = rd;
    bus.cmd.rs1        = rs1;
    bus.cmd.rs2        = rs2;
    bus.cmd.funct3     = f3;
    bus.cmd.bit30      = b30;
    bus.cmd.imm        = imm;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL cmd_accept_timeout: got no cmd_ready in 200 cycles, required accept");
        $fatal(1, "command never accepted");
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_last  = 1'b0;
    acc_cnt++;
    if (exp_ok) begin
      exp_q.push_back({model_addr, exp_word});
      model_addr += 32'd4;
    end
  endtask

  task automatic wait_done(input logic [15:0] exp_words, input logic exp_err);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 200) break;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("words_written", {16'b0, words_written}, {16'b0, exp_words});
    check("err", {31'b0, err}, {31'b0, exp_err});
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd0);
    check("idle_after_done", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f;
    rst            = 1'b1;
    start          = 1'b0;
    base_addr      = '0;
    model_addr     = '0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_last   = 1'b0;
    bus.cmd        = '0;
    bus.imem_ready = 1'b1;

    @(negedge clk);
    check("rst_wr_en", {31'b0, bus.imem_wr_en}, 32'd0);
    check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);
    check("rst_words", {16'b0, words_written}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // addi x1,x0,5
    do_start(32'h100);
    send_cmd(OpImm, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b1, 1'b1, 32'h0050_0093);
    wait_done(16'd1, 1'b0);

    // sub x3,x1,x2 ; beq x1,x2,-8
    do_start(32'h180);
    send_cmd(OpReg, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 1'b0, 1'b1, 32'h4020_81B3);
    send_cmd(OpBranch, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFF8, 1'b1, 1'b1,
             32'hFE20_8CE3);
    wait_done(16'd2, 1'b0);

    // jal x1,0x800 ; lui x5 ; srai x1,x2,3 ; sw x2,8(x1) ; jalr x0,0(x1) with f3 forced
    do_start(32'h200);
    send_cmd(OpJal, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0000_0800, 1'b0, 1'b1, 32'h0010_00EF);
    send_cmd(OpLui, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5000, 1'b0, 1'b1, 32'h1234_52B7);
    send_cmd(OpImm, 5'd1, 5'd2, 5'd0, 3'b101, 1'b1, 32'd3, 1'b0, 1'b1, 32'h4031_5093);
    send_cmd(OpStore, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8, 1'b0, 1'b1, 32'h0020_A423);
    send_cmd(OpJalr, 5'd0, 5'd1, 5'd0, 3'b111, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_8067);
    wait_done(16'd5, 1'b0);

    // Rejects: odd branch, unknown opcode, I imm out of range, U with low bits
    do_start(32'h300);
    send_cmd(OpBranch, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3, 1'b0, 1'b0, 32'h0);
    send_cmd(7'h7F, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0, 32'h0);
    send_cmd(OpImm, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h800, 1'b0, 1'b0, 32'h0);
    send_cmd(OpLui, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1, 1'b0, 1'b0, 32'h0);
    send_cmd(OpImm, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b1, 1'b1, 32'h0050_0093);
    wait_done(16'd1, 1'b1);
    do_start(32'h380);
    @(negedge clk);
    check("err_cleared", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;
    send_cmd(OpImm, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 1'b1, 1'b1, 32'h0020_0113);
    wait_done(16'd1, 1'b0);

    // Backpressure: memory stalls, FIFO fills after four accepts
    bus.imem_ready = 1'b0;
    do_start(32'h400);
    acc_cnt = 0;
    fork
      begin
        send_cmd(OpImm, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 1'b0, 1'b1, 32'h0010_0093);
        send_cmd(OpImm, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 1'b0, 1'b1, 32'h0020_0113);
        send_cmd(OpImm, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 32'd3, 1'b0, 1'b1, 32'h0030_0193);
        send_cmd(OpImm, 5'd4, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4, 1'b0, 1'b1, 32'h0040_0213);
        send_cmd(OpImm, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b0, 1'b1, 32'h0050_0293);
        send_cmd(OpImm, 5'd6, 5'd0, 5'd0, 3'b000, 1'b0, 32'd6, 1'b1, 1'b1, 32'h0060_0313);
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("accepts_when_full", acc_cnt, 32'd4);
        check("cmd_ready_full", {31'b0, bus.cmd_ready}, 32'd0);
        @(posedge clk);
        #1 bus.imem_ready = 1'b1;
      end
    join
    wait_done(16'd6, 1'b0);

    // Reset mid-drain with three queued words; a second start mid-run must be ignored
    bus.imem_ready = 1'b0;
    do_start(32'h500);
    send_cmd(OpImm, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 1'b0, 1'b0, 32'h0);
    start     = 1'b1;
    base_addr = 32'h800;
    @(posedge clk);
    #1 start = 1'b0;
    send_cmd(OpImm, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 1'b0, 1'b0, 32'h0);
    send_cmd(OpImm, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 32'd3, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("drain_busy", {31'b0, busy}, 32'd1);
    check("start_ignored_addr", bus.imem_addr, 32'h500);
    check("drain_wr_en", {31'b0, bus.imem_wr_en}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_wr_en", {31'b0, bus.imem_wr_en}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_addr", bus.imem_addr, 32'd0);
    check("arst_words", {16'b0, words_written}, 32'd0);
    f = fire_cnt;
    bus.imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_write_after_rst", fire_cnt, f);
    check("post_rst_wr_en", {31'b0, bus.imem_wr_en}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
